stream_priority_arbiter: RTL and testbench



---
 rtl/stream_priority_arbiter.sv | 132 +++++++++++++
 tb/tb_stream_priority_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/stream_priority_arbiter.sv
// Registered N-to-1 stream arbiter with packet locking.
// Fixed-priority or round-robin selection, one output register stage.
module stream_priority_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ARB_MODE   = 0,
    localparam int GRANT_W   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NUM_INPUTS-1:0]                 in_valid_i,
    input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] in_data_i,
    input  logic [NUM_INPUTS-1:0]                 in_last_i,
    output logic [NUM_INPUTS-1:0]                 in_ready_o,
    output logic                                  out_valid_o,
    output logic [DATA_WIDTH-1:0]                 out_data_o,
    output logic                                  out_last_o,
    output logic [GRANT_W-1:0]                    out_grant_o,
    input  logic                                  out_ready_i
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e               state_q, state_d;
    logic [GRANT_W-1:0]   lock_q, lock_d;
    logic [GRANT_W-1:0]   ptr_q, ptr_d;
    logic                 out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_last_q, out_last_d;
    logic [GRANT_W-1:0]   out_grant_q, out_grant_d;

    logic                 load;
    logic                 found;
    logic [GRANT_W-1:0]   win;
    logic                 xfer;

    assign load = !out_valid_q || out_ready_i;

    // Pick the winning source: locked owner, lowest index, or rotating search
    always_comb begin
        found = 1'b0;
        win   = '0;
        if (state_q == LOCKED) begin
            found = in_valid_i[lock_q];
            win   = lock_q;
        end else if (ARB_MODE == 0) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (!found && in_valid_i[i]) begin
                    found = 1'b1;
                    win   = GRANT_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                int j;
                j = (int'(ptr_q) + i) % NUM_INPUTS;
                if (!found && in_valid_i[j]) begin
                    found = 1'b1;
                    win   = GRANT_W'(j);
                end
            end
        end
    end

    // Only the winner sees ready, and only when the output register can load
    always_comb begin
        in_ready_o = '0;
        if (rst_ni && found) begin
            in_ready_o[win] = load;
        end
    end

    assign xfer = rst_ni && found && load;

    // Next-state for the output register, packet lock and rotation pointer
    always_comb begin
        state_d     = state_q;
        lock_d      = lock_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_grant_d = out_grant_q;
        if (load) begin
            out_valid_d = xfer;
        end
        if (xfer) begin
            out_data_d  = in_data_i[win];
            out_last_d  = in_last_i[win];
            out_grant_d = win;
            if (in_last_i[win]) begin
                state_d = IDLE;
                if (ARB_MODE != 0) begin
                    ptr_d = (win == GRANT_W'(NUM_INPUTS - 1)) ? '0 : win + 1'b1;
                end
            end else begin
                state_d = LOCKED;
                lock_d  = win;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            lock_q      <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_grant_q <= '0;
        end else begin
            state_q     <= state_d;
            lock_q      <= lock_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_grant_q <= out_grant_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign out_grant_o = out_grant_q;

endmodule

// File: tb/tb_stream_priority_arbiter.sv
// Directed bench for stream_priority_arbiter.
// Fixed-priority and round-robin instances share one stimulus.
module tb_stream_priority_arbiter;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      vld;
    logic [3:0]      lst;
    logic [3:0][7:0] din;
    logic            ordy;

    logic [3:0] f_irdy, r_irdy;
    logic       f_ov, r_ov;
    logic [7:0] f_od, r_od;
    logic       f_ol, r_ol;
    logic [1:0] f_og, r_og;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stream_priority_arbiter #(
        .NUM_INPUTS (4),
        .DATA_WIDTH (8),
        .ARB_MODE   (0)
    ) u_fix (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (vld),
        .in_data_i   (din),
        .in_last_i   (lst),
        .in_ready_o  (f_irdy),
        .out_valid_o (f_ov),
        .out_data_o  (f_od),
        .out_last_o  (f_ol),
        .out_grant_o (f_og),
        .out_ready_i (ordy)
    );

    stream_priority_arbiter #(
        .NUM_INPUTS (4),
        .DATA_WIDTH (8),
        .ARB_MODE   (1)
    ) u_rr (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (vld),
        .in_data_i   (din),
        .in_last_i   (lst),
        .in_ready_o  (r_irdy),
        .out_valid_o (r_ov),
        .out_data_o  (r_od),
        .out_last_o  (r_ol),
        .out_grant_o (r_og),
        .out_ready_i (ordy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        vld   = 4'b1111;
        lst   = 4'b1111;
        din   = {8'h33, 8'h22, 8'h11, 8'h00};
        ordy  = 1'b1;
        tick;
        tick;
        chk("rst_valid", 32'(f_ov), 0);
        chk("rst_data", 32'(f_od), 0);
        chk("rst_last", 32'(f_ol), 0);
        chk("rst_grant", 32'(f_og), 0);
        chk("rst_ready", 32'(f_irdy), 0);
        chk("rst_rr_valid", 32'(r_ov), 0);

        // fixed priority: 1 then 3, then drain
        rst_n = 1'b1;
        vld   = 4'b1010;
        #1 chk("fx_rdy_a", 32'(f_irdy), 32'b0010);
        tick;
        chk("fx_grant_a", 32'(f_og), 1);
        chk("fx_data_a", 32'(f_od), 32'h11);
        chk("fx_valid_a", 32'(f_ov), 1);
        chk("rr_grant_a", 32'(r_og), 1);
        vld = 4'b1000;
        #1 chk("fx_rdy_b", 32'(f_irdy), 32'b1000);
        tick;
        chk("fx_grant_b", 32'(f_og), 3);
        chk("fx_data_b", 32'(f_od), 32'h33);
        vld = 4'b0000;
        tick;
        chk("drain_valid", 32'(f_ov), 0);
        chk("drain_data", 32'(f_od), 32'h33);
        chk("drain_grant", 32'(f_og), 3);

        // round robin over all four sources
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        vld   = 4'b1111;
        lst   = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1 chk("rr_rdy", 32'(r_irdy), 32'(1) << (k % 4));
            tick;
            chk("rr_grant", 32'(r_og), 32'(k % 4));
            chk("rr_fx_grant", 32'(f_og), 0);
        end

        // packet lock on source 2
        rst_n  = 1'b0;
        tick;
        rst_n  = 1'b1;
        vld    = 4'b0100;
        lst    = 4'b0000;
        din[2] = 8'hA1;
        tick;
        chk("lk_grant_1", 32'(f_og), 2);
        chk("lk_last_1", 32'(f_ol), 0);
        vld    = 4'b0101;
        din[2] = 8'hA2;
        #1 chk("lk_rdy_2", 32'(f_irdy), 32'b0100);
        tick;
        chk("lk_grant_2", 32'(f_og), 2);
        chk("lk_data_2", 32'(f_od), 32'hA2);
        lst[2] = 1'b1;
        din[2] = 8'hA3;
        #1 chk("lk_rdy_3", 32'(f_irdy), 32'b0100);
        tick;
        chk("lk_grant_3", 32'(f_og), 2);
        chk("lk_last_3", 32'(f_ol), 1);
        chk("lk_data_3", 32'(f_od), 32'hA3);
        vld    = 4'b0001;
        lst[0] = 1'b1;
        din[0] = 8'hB0;
        #1 chk("lk_rdy_rel", 32'(f_irdy), 32'b0001);
        tick;
        chk("lk_grant_0", 32'(f_og), 0);
        chk("lk_data_0", 32'(f_od), 32'hB0);

        // backpressure for five cycles, then release
        ordy   = 1'b0;
        vld    = 4'b0010;
        lst    = 4'b1111;
        din[1] = 8'h5A;
        for (int k = 0; k < 5; k++) begin
            #1 chk("bp_rdy", 32'(f_irdy), 0);
            tick;
            chk("bp_data", 32'(f_od), 32'hB0);
            chk("bp_grant", 32'(f_og), 0);
            chk("bp_valid", 32'(f_ov), 1);
        end
        ordy = 1'b1;
        #1 chk("bp_rel_rdy", 32'(f_irdy), 32'b0010);
        tick;
        chk("bp_rel_grant", 32'(f_og), 1);
        chk("bp_rel_data", 32'(f_od), 32'h5A);
        chk("bp_rel_valid", 32'(f_ov), 1);
        vld = 4'b0000;
        tick;

        // reset in the middle of a packet from source 1
        vld    = 4'b0010;
        lst    = 4'b0000;
        din[1] = 8'h71;
        tick;
        chk("mr_grant_1", 32'(f_og), 1);
        rst_n = 1'b0;
        vld   = 4'b0011;
        lst   = 4'b1111;
        #1 chk("mr_rdy_rst", 32'(f_irdy), 0);
        tick;
        chk("mr_valid", 32'(f_ov), 0);
        chk("mr_data", 32'(f_od), 0);
        chk("mr_last", 32'(f_ol), 0);
        chk("mr_grant", 32'(f_og), 0);
        rst_n = 1'b1;
        #1 chk("mr_rdy_after", 32'(f_irdy), 32'b0001);
        tick;
        chk("mr_win_grant", 32'(f_og), 0);
        chk("mr_win_data", 32'(f_od), 32'hB0);
        chk("mr_win_valid", 32'(f_ov), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
